// File: rtl/bldc_motor_pwm.sv
// Six-step BLDC commutation with a chopped high-side PWM and post-commutation dead time.
// Hall inputs are synchronised; all gate outputs are registered and never drive 2'b11.
module bldc_motor_pwm #(
    parameter int PWM_W       = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [PWM_W-1:0] Input,
    input  logic [2:0]       H,
    output logic [1:0]       A,
    output logic [1:0]       B,
    output logic [1:0]       C
);

    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

    logic [2:0]       h_meta;
    logic [2:0]       h_s;
    logic [2:0]       h_prev;
    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_q;
    logic [DW-1:0]    dead_q;
    logic [DW-1:0]    dead_d;
    logic             hall_change;
    logic             pwm;
    logic [2:0]       hi_sel;
    logic [2:0]       lo_sel;
    logic [1:0]       a_d;
    logic [1:0]       b_d;
    logic [1:0]       c_d;

    assign hall_change = (h_s != h_prev);
    assign pwm         = (cnt < duty_q);

    // Blanking uses the next counter value so a change blanks from its first output cycle.
    always_comb begin
        dead_d = '0;
        if (hall_change) begin
            dead_d = DW'(DEAD_CYCLES);
        end else if (dead_q != '0) begin
            dead_d = dead_q - DW'(1);
        end
    end

    // hi_sel / lo_sel are one-hot over {A,B,C}; invalid codes select nothing.
    always_comb begin
        hi_sel = 3'b000;
        lo_sel = 3'b000;
        case (h_s)
            3'b101: begin hi_sel = 3'b100; lo_sel = 3'b010; end
            3'b100: begin hi_sel = 3'b100; lo_sel = 3'b001; end
            3'b110: begin hi_sel = 3'b010; lo_sel = 3'b001; end
            3'b010: begin hi_sel = 3'b010; lo_sel = 3'b100; end
            3'b011: begin hi_sel = 3'b001; lo_sel = 3'b100; end
            3'b001: begin hi_sel = 3'b001; lo_sel = 3'b010; end
            default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
        endcase
        if (dead_d != '0) begin
            hi_sel = 3'b000;
            lo_sel = 3'b000;
        end
        a_d = {hi_sel[2] & pwm, lo_sel[2]};
        b_d = {hi_sel[1] & pwm, lo_sel[1]};
        c_d = {hi_sel[0] & pwm, lo_sel[0]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_meta <= 3'b000;
            h_s    <= 3'b000;
            h_prev <= 3'b000;
            cnt    <= '0;
            duty_q <= '0;
            dead_q <= '0;
            A      <= 2'b00;
            B      <= 2'b00;
            C      <= 2'b00;
        end else begin
            h_meta <= H;
            h_s    <= h_meta;
            h_prev <= h_s;
            cnt    <= cnt + PWM_W'(1);
            // New duty only takes effect at a period boundary.
            if (cnt == '1) begin
                duty_q <= Input;
            end
            dead_q <= dead_d;
            A      <= a_d;
            B      <= b_d;
            C      <= c_d;
        end
    end

endmodule

// File: tb/tb_bldc_motor_pwm.sv
// Bench for bldc_motor_pwm: directed scenarios plus random hall/duty traffic,
// checked every cycle against a history-based reference model.
module tb_bldc_motor_pwm;

    localparam int PW     = 4;
    localparam int DEAD   = 2;
    localparam int PERIOD = 1 << PW;
    localparam int HMAX   = 8192;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [PW-1:0] Input = '0;
    logic [2:0]    H = 3'b000;
    logic [1:0]    A;
    logic [1:0]    B;
    logic [1:0]    C;

    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_n = 0;
    logic checking = 1'b0;
    logic [2:0]    hist_h  [0:HMAX-1];
    logic [PW-1:0] hist_in [0:HMAX-1];

    bldc_motor_pwm #(.PWM_W(PW), .DEAD_CYCLES(DEAD)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Input (Input),
        .H     (H),
        .A     (A),
        .B     (B),
        .C     (C)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Edge n (1-based since reset release) records the inputs seen at that edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_n <= 0;
        end else if (edge_n < HMAX - 1) begin
            edge_n              <= edge_n + 1;
            hist_h[edge_n + 1]  <= H;
            hist_in[edge_n + 1] <= Input;
        end
    end

    // Synchronised hall code acting on edge m: the raw hall value two edges earlier.
    function automatic logic [2:0] sync_code(input int m);
        return (m >= 3) ? hist_h[m-2] : 3'b000;
    endfunction

    // Expected {A,B,C} right after edge n.
    function automatic logic [5:0] model(input int n);
        logic [1:0] g [3];
        int hi, lo, p, duty;
        logic blank, on;
        g[0] = 2'b00; g[1] = 2'b00; g[2] = 2'b00;
        if (n == 0) return 6'b0;
        blank = 1'b0;
        for (int m = n - DEAD + 1; m <= n; m++)
            if (m >= 1 && sync_code(m) != sync_code(m-1)) blank = 1'b1;
        p    = (n - 1) / PERIOD;
        duty = (p == 0) ? 0 : int'(hist_in[p*PERIOD]);
        on   = ((n - 1) % PERIOD) < duty;
        hi = -1; lo = -1;
        case (sync_code(n))
            3'b101: begin hi = 0; lo = 1; end
            3'b100: begin hi = 0; lo = 2; end
            3'b110: begin hi = 1; lo = 2; end
            3'b010: begin hi = 1; lo = 0; end
            3'b011: begin hi = 2; lo = 0; end
            3'b001: begin hi = 2; lo = 1; end
            default: begin hi = -1; lo = -1; end
        endcase
        if (!blank && hi >= 0) begin
            g[hi] = {on, 1'b0};
            g[lo] = 2'b01;
        end
        return {g[0], g[1], g[2]};
    endfunction

    always @(negedge CLK) begin
        if (checking) begin
            check("gates", {26'b0, A, B, C}, RST ? 32'd0 : {26'b0, model(edge_n)});
            check("no_11", {31'b0, (A != 2'b11) && (B != 2'b11) && (C != 2'b11)}, 32'd1);
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge CLK);
        #1;
    endtask

    task automatic count_high(input int which, input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            @(negedge CLK);
            case (which)
                0: if (A[1]) hits++;
                1: if (B[1]) hits++;
                default: if (C[1]) hits++;
            endcase
        end
    endtask

    initial begin
        int hits;
        int g;
        #1;
        RST = 1'b1;
        H = 3'b101;
        Input = 4'd8;
        checking = 1'b1;

        // Reset, then A high-side chopped at 8/16, B low-side on
        step(3);
        RST = 1'b0;
        step(40);
        count_high(0, 16, hits);
        check("t1_a_on", hits, 8);
        check("t1_b", {30'b0, B}, 32'd1);
        check("t1_c", {30'b0, C}, 32'd0);

        // Walk through every hall code
        for (int h = 0; h < 8; h++) begin
            H = 3'(h);
            step(100);
        end

        // Zero duty: high side never on
        Input = 4'd0;
        H = 3'b110;
        step(50);
        count_high(1, 32, hits);
        check("t3_b_never", hits, 0);

        // Maximum duty: 15 of 16
        Input = 4'd15;
        H = 3'b011;
        step(50);
        count_high(2, 16, hits);
        check("t4_c_on", hits, 15);
        check("t4_a", {30'b0, A}, 32'd1);

        // Mid-period duty change takes effect only next period
        Input = 4'd4;
        H = 3'b101;
        step(40);
        g = 0;
        while (g < 40 && (edge_n % PERIOD) != 0) begin
            @(negedge CLK);
            g++;
        end
        check("t5_sync", {31'b0, (edge_n % PERIOD) == 0}, 32'd1);
        hits = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge CLK);
            if (A[1]) hits++;
            if (i == 5) begin
                #1;
                Input = 4'd12;
            end
        end
        check("t5_cur", hits, 4);
        count_high(0, PERIOD, hits);
        check("t5_next", hits, 12);

        // Random hall / duty traffic
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 3) != 0) H = 3'($urandom_range(0, 7));
            Input = PW'($urandom_range(0, PERIOD - 1));
            step($urandom_range(1, 40));
        end

        // Asynchronous reset while gates are on
        H = 3'b100;
        Input = 4'd10;
        step(40);
        check("t6_pre", {31'b0, {A, B, C} != 6'b0}, 32'd1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("t6_async", {26'b0, A, B, C}, 32'd0);
        step(3);
        RST = 1'b0;
        step(40);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
